// File: rtl/tsp_board_pkg.sv
// Shared board-level types and default timing constants for the TSP Zedboard wrapper.
package tsp_board_pkg;

  typedef enum logic {
    SHOW_DATA = 1'b0,
    SHOW_PAGE = 1'b1
  } monitor_state_t;

  localparam int unsigned CLK_HZ      = 100_000_000;
  localparam int unsigned DEBOUNCE_MS = 10;
  localparam int unsigned FLASH_MS    = 500;

endpackage

// File: rtl/tsp_btn_debounce.sv
// Button synchroniser and debouncer; emits a one-cycle pulse on the accepted rising level.
module tsp_btn_debounce
  import tsp_board_pkg::*;
#(
  parameter  int unsigned CYCLES = CLK_HZ / 1000 * DEBOUNCE_MS,
  localparam int unsigned CNT_W  = $clog2(CYCLES)
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn,
  output logic rise
);

  logic             sync0;
  logic             sync1;
  logic             btn_db;
  logic             armed;
  logic [1:0]       fill;
  logic [CNT_W-1:0] cnt;
  logic             accept;

  assign accept = (sync1 != btn_db) && (cnt == CNT_W'(CYCLES - 1));
  assign rise   = accept && sync1 && armed;

  // A press still held when reset releases is debounced but not reported:
  // reporting is armed only once a released level has been seen after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync0  <= 1'b0;
      sync1  <= 1'b0;
      btn_db <= 1'b0;
      armed  <= 1'b0;
      fill   <= '0;
      cnt    <= '0;
    end else begin
      sync0 <= btn;
      sync1 <= sync0;
      fill  <= {fill[0], 1'b1};
      if (sync1 == btn_db) begin
        cnt <= '0;
      end else if (accept) begin
        btn_db <= sync1;
        cnt    <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
      if (fill[1] && !sync1 && !btn_db) begin
        armed <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/tsp_led_monitor.sv
// Holds TSP status words and shows a selectable LED-wide slice; a button steps pages and flashes the index.
module tsp_led_monitor
  import tsp_board_pkg::*;
#(
  parameter  int unsigned NUM_CH          = 1,
  parameter  int unsigned WORD_W          = 32,
  parameter  int unsigned LED_W           = 8,
  parameter  int unsigned DEBOUNCE_CYCLES = CLK_HZ / 1000 * DEBOUNCE_MS,
  parameter  int unsigned FLASH_CYCLES    = CLK_HZ / 1000 * FLASH_MS,
  localparam int unsigned SLICES          = WORD_W / LED_W,
  localparam int unsigned PAGES           = NUM_CH * SLICES,
  localparam int unsigned PAGE_W          = (PAGES > 1) ? $clog2(PAGES) : 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_CH*WORD_W-1:0] ch_data,
  input  logic [NUM_CH-1:0]        ch_valid,
  input  logic                     btn,
  output logic [LED_W-1:0]         led,
  output logic [PAGE_W-1:0]        page,
  output logic                     flashing
);

  localparam int unsigned FC_W = (FLASH_CYCLES > 1) ? $clog2(FLASH_CYCLES) : 1;

  if (NUM_CH < 1 || (WORD_W % LED_W) != 0 || PAGES > (2 ** LED_W)) begin : g_bad_cfg
    $error("tsp_led_monitor: invalid NUM_CH/WORD_W/LED_W combination");
  end

  monitor_state_t           state;
  monitor_state_t           state_nx;
  logic [PAGE_W-1:0]        page_nx;
  logic [FC_W-1:0]          fcnt;
  logic [FC_W-1:0]          fcnt_nx;
  logic [LED_W-1:0]         data_sel;
  logic [LED_W-1:0]         led_nx;
  logic [NUM_CH*WORD_W-1:0] hold;
  logic                     step;

  tsp_btn_debounce #(
    .CYCLES(DEBOUNCE_CYCLES)
  ) u_btn_debounce (
    .clk  (clk),
    .rst_n(rst_n),
    .btn  (btn),
    .rise (step)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold <= '0;
    end else begin
      for (int unsigned c = 0; c < NUM_CH; c++) begin
        if (ch_valid[c]) begin
          hold[c*WORD_W +: WORD_W] <= ch_data[c*WORD_W +: WORD_W];
        end
      end
    end
  end

  // Channels are packed back to back, so page p is simply slice p of the flat hold vector.
  always_comb begin
    data_sel = '0;
    for (int unsigned p = 0; p < PAGES; p++) begin
      if (page_nx == PAGE_W'(p)) begin
        data_sel = hold[p*LED_W +: LED_W];
      end
    end
  end

  always_comb begin
    state_nx = state;
    page_nx  = page;
    fcnt_nx  = fcnt;
    if (step) begin
      page_nx  = (page == PAGE_W'(PAGES - 1)) ? '0 : page + 1'b1;
      state_nx = SHOW_PAGE;
      fcnt_nx  = FC_W'(FLASH_CYCLES - 1);
    end else begin
      unique case (state)
        SHOW_DATA: ;
        SHOW_PAGE: begin
          if (fcnt == '0) begin
            state_nx = SHOW_DATA;
          end else begin
            fcnt_nx = fcnt - 1'b1;
          end
        end
        default: state_nx = SHOW_DATA;
      endcase
    end
    led_nx = (state_nx == SHOW_PAGE) ? LED_W'(page_nx) : data_sel;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= SHOW_DATA;
      page     <= '0;
      fcnt     <= '0;
      led      <= '0;
      flashing <= 1'b0;
    end else begin
      state    <= state_nx;
      page     <= page_nx;
      fcnt     <= fcnt_nx;
      led      <= led_nx;
      flashing <= (state_nx == SHOW_PAGE);
    end
  end

endmodule

// File: tb/tb_tsp_led_monitor.sv
// Self-checking bench for tsp_led_monitor: table-driven paging plus hand-written corner sequences.
module tb_tsp_led_monitor;

  localparam int unsigned NUM_CH = 2;
  localparam int unsigned WORD_W = 32;
  localparam int unsigned LED_W  = 8;
  localparam int unsigned DB     = 4;
  localparam int unsigned FL     = 8;

  logic        clk      = 1'b0;
  logic        rst_n    = 1'b0;
  logic [63:0] ch_data  = '0;
  logic [1:0]  ch_valid = '0;
  logic        btn      = 1'b0;
  logic [7:0]  led;
  logic [2:0]  page;
  logic        flashing;

  always #5 clk = ~clk;

  tsp_led_monitor #(
    .NUM_CH         (NUM_CH),
    .WORD_W         (WORD_W),
    .LED_W          (LED_W),
    .DEBOUNCE_CYCLES(DB),
    .FLASH_CYCLES   (FL)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .ch_data (ch_data),
    .ch_valid(ch_valid),
    .btn     (btn),
    .led     (led),
    .page    (page),
    .flashing(flashing)
  );

  typedef struct {
    int unsigned due;
    logic [7:0]  led;
    logic [2:0]  page;
    logic        flashing;
    string       name;
  } exp_t;

  typedef struct {
    logic [2:0] page;
    logic [7:0] flash_led;
    logic [7:0] data_led;
  } vec_t;

  exp_t        sb[$];
  vec_t        vecs[8];
  int unsigned cyc = 0;
  int          checks = 0;
  int          failures = 0;
  logic [7:0]  cur_led;
  logic [2:0]  cur_page;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string n, input logic [7:0] l, input logic [2:0] p, input logic f);
    checks++;
    if (led !== l || page !== p || flashing !== f) begin
      failures++;
      $display("FAIL %s cyc=%0d: got led=%02h page=%0d flashing=%b, want led=%02h page=%0d flashing=%b",
               n, cyc, led, page, flashing, l, p, f);
    end
  endtask

  always @(negedge clk) begin
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].due == cyc) begin
        check(sb[i].name, sb[i].led, sb[i].page, sb[i].flashing);
        sb.delete(i);
      end
    end
  end

  function automatic void expect_at(input int unsigned due, input logic [7:0] l,
                                    input logic [2:0] p, input logic f, input string n);
    exp_t e;
    e.due = due; e.led = l; e.page = p; e.flashing = f; e.name = n;
    sb.push_back(e);
  endfunction

  // Flash of FL cycles starting at edge s, then data on the following edge.
  function automatic void expect_flash(input int unsigned s, input logic [7:0] fl_led,
                                       input logic [2:0] p, input logic [7:0] data, input string n);
    for (int unsigned d = 0; d < FL; d++) expect_at(s + d, fl_led, p, 1'b1, n);
    expect_at(s + FL, data, p, 1'b0, {n, "_ret"});
  endfunction

  function automatic void expect_idle(input int unsigned from, input int unsigned n_cyc, input string n);
    for (int unsigned k = 0; k < n_cyc; k++) expect_at(from + k, 8'h00, 3'd0, 1'b0, n);
  endfunction

  task automatic ticks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic async_reset_check(input string n);
    #2 rst_n = 1'b0;
    #1 check(n, 8'h00, 3'd0, 1'b0);
    sb.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, time=%0t", $time);
    $fatal(1);
  end

  initial begin
    int unsigned c;
    vecs[0] = '{3'd1, 8'h01, 8'hBE};
    vecs[1] = '{3'd2, 8'h02, 8'hAD};
    vecs[2] = '{3'd3, 8'h03, 8'hDE};
    vecs[3] = '{3'd4, 8'h04, 8'h0D};
    vecs[4] = '{3'd5, 8'h05, 8'hF0};
    vecs[5] = '{3'd6, 8'h06, 8'hFE};
    vecs[6] = '{3'd7, 8'h07, 8'hCA};
    vecs[7] = '{3'd0, 8'h00, 8'hEF};

    ticks(3);
    check("reset_state", 8'h00, 3'd0, 1'b0);
    rst_n = 1'b1;
    ticks(3);

    // Hold register latency and channel independence.
    c = cyc;
    ch_data = {32'h0000_0000, 32'hDEAD_BEEF};
    ch_valid = 2'b01;
    expect_at(c + 1, 8'h00, 3'd0, 1'b0, "hold_lat1");
    expect_at(c + 2, 8'hEF, 3'd0, 1'b0, "hold_lat2");
    ticks(1);
    ch_valid = 2'b00;
    ticks(3);
    c = cyc;
    ch_data = {32'hCAFE_F00D, 32'h0000_0000};
    ch_valid = 2'b10;
    expect_at(c + 2, 8'hEF, 3'd0, 1'b0, "ch1_load_ch0_kept");
    expect_at(c + 3, 8'hEF, 3'd0, 1'b0, "ch1_load_ch0_kept");
    ticks(1);
    ch_valid = 2'b00;
    ticks(4);
    cur_led = 8'hEF;
    cur_page = 3'd0;

    // Eight clean presses: pages 1..7 then wrap to 0.
    for (int v = 0; v < 8; v++) begin
      c = cyc;
      btn = 1'b1;
      expect_at(c + 5, cur_led, cur_page, 1'b0, "press_pre");
      expect_flash(c + 6, vecs[v].flash_led, vecs[v].page, vecs[v].data_led, "press");
      ticks(10);
      btn = 1'b0;
      ticks(12);
      cur_led = vecs[v].data_led;
      cur_page = vecs[v].page;
    end

    // Second step lands on the flash's final cycle: stays in SHOW_PAGE.
    c = cyc;
    btn = 1'b1;
    expect_at(c + 5, 8'hEF, 3'd0, 1'b0, "sdf_pre");
    for (int unsigned d = 0; d < FL; d++) expect_at(c + 6 + d, 8'h01, 3'd1, 1'b1, "sdf_first");
    for (int unsigned d = 0; d < FL; d++) expect_at(c + 14 + d, 8'h02, 3'd2, 1'b1, "sdf_second");
    expect_at(c + 22, 8'hAD, 3'd2, 1'b0, "sdf_ret");
    ticks(4);
    btn = 1'b0;
    ticks(4);
    btn = 1'b1;
    ticks(8);
    btn = 1'b0;
    ticks(16);

    // Bounce every 2 cycles for 20 cycles, then hold high: one step, 6 edges after the final rise.
    c = cyc;
    for (int unsigned k = 1; k <= 25; k++) expect_at(c + k, 8'hAD, 3'd2, 1'b0, "bounce_reject");
    expect_flash(c + 26, 8'h03, 3'd3, 8'hDE, "bounce_step");
    for (int k = 0; k < 5; k++) begin
      btn = 1'b1;
      ticks(2);
      btn = 1'b0;
      ticks(2);
    end
    btn = 1'b1;
    ticks(15);
    btn = 1'b0;
    ticks(10);

    // Hold update while the page index is flashing.
    c = cyc;
    btn = 1'b1;
    expect_at(c + 5, 8'hDE, 3'd3, 1'b0, "upd_pre");
    expect_flash(c + 6, 8'h04, 3'd4, 8'h78, "upd_flash");
    ticks(8);
    ch_data = {32'h1234_5678, 32'hFFFF_FFFF};
    ch_valid = 2'b10;
    ticks(1);
    ch_valid = 2'b00;
    ticks(1);
    btn = 1'b0;
    ticks(14);

    // Reset mid-debounce with the button held through reset.
    btn = 1'b1;
    ticks(3);
    async_reset_check("rst_mid_debounce");
    ticks(2);
    rst_n = 1'b1;
    expect_idle(cyc + 1, 20, "held_after_rst1");
    ticks(22);
    btn = 1'b0;
    ticks(10);

    // Fresh press counts; reset mid-flash with button held.
    c = cyc;
    btn = 1'b1;
    expect_at(c + 5, 8'h00, 3'd0, 1'b0, "repress_pre");
    expect_flash(c + 6, 8'h01, 3'd1, 8'h00, "repress");
    ticks(8);
    async_reset_check("rst_mid_flash");
    ticks(2);
    rst_n = 1'b1;
    expect_idle(cyc + 1, 20, "held_after_rst2");
    ticks(22);
    btn = 1'b0;
    ticks(10);

    c = cyc;
    btn = 1'b1;
    expect_at(c + 5, 8'h00, 3'd0, 1'b0, "final_pre");
    expect_flash(c + 6, 8'h01, 3'd1, 8'h00, "final_press");
    ticks(10);
    btn = 1'b0;
    ticks(12);

    while (sb.size() > 0) begin
      checks++;
      failures++;
      $display("FAIL drain %s: expectation due at cyc=%0d never compared (now %0d)",
               sb[0].name, sb[0].due, cyc);
      void'(sb.pop_front());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
